// File: rtl/cpe_dmem_resp.sv
// Data-memory responder: single-port word RAM behind the CPU load/store strobes.
// Word stores complete in one cycle; loads and sub-word stores take a second RAM cycle.
module cpe_dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 32
) (
  input  logic          clk_w_i,
  input  logic          res_w_i_h,
  input  logic [AW-1:0] addr_w_i,
  input  logic [31:0]   wr_data_w_i,
  input  logic          mem_wr_w_i_h,
  input  logic          mem_rd_w_i_h,
  input  logic [1:0]    mem_byte_sel_w_i,
  output logic [31:0]   rd_data_w_o,
  output logic          ack_w_o_h,
  output logic          err_w_o_h,
  output logic          busy_w_o_h
);

  localparam int WI = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_MERGE} state_t;

  state_t        state_q;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [WI-1:0] widx_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rword_q;
  logic [31:0]   rd_data_q;
  logic          ack_q;
  logic          err_q;

  // Request decode, only meaningful while IDLE.
  logic [WI-1:0] widx;
  logic          out_of_range;
  logic          req;
  logic          bad;
  logic          word_store;

  assign widx         = addr_w_i[WI+1:2];
  assign out_of_range = |(addr_w_i >> (WI + 2));
  assign req          = mem_rd_w_i_h | mem_wr_w_i_h;
  assign bad          = (mem_byte_sel_w_i == 2'b11)
                      | ((mem_byte_sel_w_i == 2'b01) & addr_w_i[0])
                      | ((mem_byte_sel_w_i == 2'b10) & (addr_w_i[1:0] != 2'b00))
                      | out_of_range
                      | (mem_rd_w_i_h & mem_wr_w_i_h);
  assign word_store   = mem_wr_w_i_h & (mem_byte_sel_w_i == 2'b10);

  // Lane shift and size mask shared by the load extract and the store merge.
  logic [4:0]  shamt;
  logic [31:0] size_mask;
  logic [31:0] rd_ext;
  logic [31:0] merged;

  assign shamt  = {lane_q, 3'b000};
  assign rd_ext = (rword_q >> shamt) & size_mask;
  assign merged = (rword_q & ~(size_mask << shamt)) | ((wdata_q << shamt) & (size_mask << shamt));

  // RAM port control: at most one access per edge; writes are blocked under reset.
  logic          mem_we;
  logic          mem_re;
  logic [WI-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' with a default for every output first, so no latch is inferred.
    size_mask = 32'hFFFF_FFFF;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = widx;
    mem_wdata = wr_data_w_i;
    case (size_q)
      2'b00:   size_mask = 32'h0000_00FF;
      2'b01:   size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
    if (state_q == IDLE) begin
      if (req && !bad) begin
        mem_we = word_store;
        mem_re = !word_store;
      end
    end else if (state_q == RMW_MERGE) begin
      mem_we    = 1'b1;
      mem_addr  = widx_q;
      mem_wdata = merged;
    end
    if (res_w_i_h) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // NOTE: the RAM array and its read register have no reset, so this maps onto a plain block RAM.
  always_ff @(posedge clk_w_i) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end else if (mem_re) begin
      rword_q <= mem_q[mem_addr];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only, so every register sees pre-edge values.
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            widx_q  <= widx;
            lane_q  <= addr_w_i[1:0];
            size_q  <= mem_byte_sel_w_i;
            wdata_q <= wr_data_w_i;
            if (bad) begin
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else if (word_store) begin
              ack_q <= 1'b1;
            end else if (mem_rd_w_i_h) begin
              state_q <= RD_WAIT;
            end else begin
              state_q <= RMW_MERGE;
            end
          end
        end
        RD_WAIT: begin
          rd_data_q <= rd_ext;
          ack_q     <= 1'b1;
          state_q   <= IDLE;
        end
        RMW_MERGE: begin
          ack_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data_w_o = rd_data_q;
  assign ack_w_o_h   = ack_q;
  assign err_w_o_h   = err_q;
  assign busy_w_o_h  = (state_q != IDLE);

endmodule

// File: tb/tb_cpe_dmem_resp.sv
// Directed bench for cpe_dmem_resp: stimulus pushes expected completions into a queue
// that a negedge monitor pops whenever the responder acknowledges.
module tb_cpe_dmem_resp;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        res;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [1:0]  sel;
  logic [31:0] rd_data;
  logic        ack;
  logic        err;
  logic        busy;

  cpe_dmem_resp #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (
    .clk_w_i          (clk),
    .res_w_i_h        (res),
    .addr_w_i         (addr),
    .wr_data_w_i      (wdata),
    .mem_wr_w_i_h     (wr),
    .mem_rd_w_i_h     (rd),
    .mem_byte_sel_w_i (sel),
    .rd_data_w_o      (rd_data),
    .ack_w_o_h        (ack),
    .err_w_o_h        (err),
    .busy_w_o_h       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (res === 1'b0) begin
      if (ack === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with no outstanding request at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_err", {31'b0, err}, {31'b0, e.err});
          if (e.chk_data) check("rd_data", rd_data, e.data);
        end
      end else if (ack === 1'b0) begin
        check("err_without_ack", {31'b0, err}, 32'h0);
      end
    end
  end

  // Present one request for one edge, then measure how many extra edges until ack.
  task automatic issue(input string name, input logic r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input logic exp_err, input logic chk_data,
                       input int lat);
    exp_t e;
    int   seen;
    @(negedge clk);
    rd = r; wr = w; sel = s; addr = a; wdata = d;
    e = '{exp_data, exp_err, chk_data};
    sb.push_back(e);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    seen = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check({name, "_busy"}, {31'b0, busy}, {31'b0, lat == 1});
      if (ack === 1'b1) begin
        seen = i;
        break;
      end
    end
    check({name, "_latency"}, seen, lat);
  endtask

  task automatic st(input string n, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    issue(n, 1'b0, 1'b1, s, a, d, 32'h0, 1'b0, 1'b0, (s == 2'b10) ? 0 : 1);
  endtask

  task automatic ld(input string n, input logic [1:0] s, input logic [31:0] a, input logic [31:0] exp);
    issue(n, 1'b1, 1'b0, s, a, 32'h0, exp, 1'b0, 1'b1, 1);
  endtask

  task automatic bad(input string n, input logic r, input logic w, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    issue(n, r, w, s, a, d, 32'h0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res = 1'b1; rd = 1'b0; wr = 1'b0; sel = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);

    // Word store then load.
    st("st_w10", 2'b10, 32'h10, 32'hDEAD_BEEF);
    ld("ld_w10", 2'b10, 32'h10, 32'hDEAD_BEEF);

    // Byte read-modify-write.
    st("st_w20", 2'b10, 32'h20, 32'h1122_3344);
    st("st_b22", 2'b00, 32'h22, 32'hFFFF_FFAA);
    ld("ld_w20", 2'b10, 32'h20, 32'h11AA_3344);

    // Sub-word loads and a half store.
    st("st_w30", 2'b10, 32'h30, 32'h8899_AABB);
    ld("ld_b33", 2'b00, 32'h33, 32'h0000_0088);
    ld("ld_h32", 2'b01, 32'h32, 32'h0000_8899);
    ld("ld_b30", 2'b00, 32'h30, 32'h0000_00BB);
    st("st_h30", 2'b01, 32'h30, 32'h1234_5566);
    ld("ld_w30", 2'b10, 32'h30, 32'h8899_5566);

    // Rejected requests leave memory untouched.
    bad("err_half_odd", 1'b1, 1'b0, 2'b01, 32'h31, 32'h0);
    bad("err_word_mis", 1'b1, 1'b0, 2'b10, 32'h42, 32'h0);
    bad("err_sel11",    1'b1, 1'b0, 2'b11, 32'h40, 32'h0);
    bad("err_range",    1'b0, 1'b1, 2'b10, DEPTH * 4, 32'hFFFF_FFFF);
    bad("err_range_hi", 1'b0, 1'b1, 2'b10, 32'h8000_0030, 32'hFFFF_FFFF);
    bad("err_rdwr",     1'b1, 1'b1, 2'b10, 32'h30, 32'h0);
    bad("err_st_half",  1'b0, 1'b1, 2'b01, 32'h31, 32'hFFFF_FFFF);
    ld("ld_w30_after", 2'b10, 32'h30, 32'h8899_5566);
    ld("ld_w00_after", 2'b10, 32'h00 + (DEPTH * 4 - 4 == 0 ? 0 : 32'h10), 32'hDEAD_BEEF);

    // Highest word is reachable and does not alias low memory.
    st("st_top", 2'b10, DEPTH * 4 - 4, 32'hCAFE_F00D);
    ld("ld_top", 2'b10, DEPTH * 4 - 4, 32'hCAFE_F00D);
    ld("ld_b_top", 2'b00, DEPTH * 4 - 1, 32'h0000_00CA);
    ld("ld_w10_again", 2'b10, 32'h10, 32'hDEAD_BEEF);

    // Reset at the merge edge suppresses the write.
    st("st_w50", 2'b10, 32'h50, 32'h0);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; sel = 2'b00; addr = 32'h50; wdata = 32'hFF;
    @(posedge clk);
    #1;
    wr = 1'b0; res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    check("rmw_reset_ack", {31'b0, ack}, 32'h0);
    check("rmw_reset_busy", {31'b0, busy}, 32'h0);
    check("rmw_reset_rd_data", rd_data, 32'h0);
    ld("ld_w50", 2'b10, 32'h50, 32'h0);

    // Store presented while a load is in RD_WAIT is ignored.
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; sel = 2'b10; addr = 32'h10; wdata = 32'h0;
    sb.push_back('{32'hDEAD_BEEF, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b1; sel = 2'b10; addr = 32'h10; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 wr = 1'b0;
    repeat (3) @(negedge clk);
    ld("ld_w10_busy", 2'b10, 32'h10, 32'hDEAD_BEEF);

    // Reset during RD_WAIT: no ack and rd_data cleared.
    @(negedge clk);
    rd = 1'b1; sel = 2'b10; addr = 32'h20;
    @(posedge clk);
    #1;
    rd = 1'b0; res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    check("rdwait_reset_ack", {31'b0, ack}, 32'h0);
    check("rdwait_reset_rd_data", rd_data, 32'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
